counter_share_arbiter: RTL

- Owns one shared 5-bit saturating up/down counter, used as a credit/resource pool, and shares it between N_REQ requesters.
- Each requester asks for an increment (release) or a decrement (acquire).
- A round-robin arbiter grants at most one eligible request per cycle and applies it to the counter in the same edge.
- Sits between requesting agents and the pool; also exposes load, high and low like a standalone counter.

---
 rtl/counter_share_arbiter_pkg.sv | 20 ++
 rtl/counter_share_arbiter_rr_arbiter.sv | 33 +++
 rtl/counter_share_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/counter_share_arbiter_pkg.sv
// Shared constants and helpers for the counter_share_arbiter slice.
package counter_share_arbiter_pkg;

    localparam logic OP_UP   = 1'b0;
    localparam logic OP_DOWN = 1'b1;

    // Index width for an N-entry vector; callers guarantee n >= 2.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after i_ptr, with wrap.
module rr_arbiter
    import counter_share_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          i_elig,
    input  logic [clog2(N)-1:0]   i_ptr,
    output logic [N-1:0]          o_onehot,
    output logic [clog2(N)-1:0]   o_idx,
    output logic                  o_any
);

    localparam int unsigned IW = clog2(N);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = IW'((32'(i_ptr) + k) % N);
            if (!o_any && i_elig[w_cand]) begin
                o_any            = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_share_arbiter.sv
// Saturating up/down credit counter shared between N_REQ requesters via round-robin grants.
module counter_share_arbiter
    import counter_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_op,
    input  logic                      i_load,
    input  logic [WIDTH-1:0]          i_load_val,
    output logic [N_REQ-1:0]          o_gnt,
    output logic                      o_gnt_vld,
    output logic [clog2(N_REQ)-1:0]   o_gnt_id,
    output logic [WIDTH-1:0]          o_count,
    output logic                      o_high,
    output logic                      o_low
);

    localparam int unsigned IW = clog2(N_REQ);

    logic [WIDTH-1:0] r_count;
    logic [N_REQ-1:0] r_gnt;
    logic             r_gnt_vld;
    logic [IW-1:0]    r_gnt_id;
    logic [IW-1:0]    r_ptr;

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_onehot;
    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic [IW-1:0]    w_ptr_nxt;
    logic             w_high;
    logic             w_low;

    assign w_high = (r_count == '1);
    assign w_low  = (r_count == '0);

    // Saturation is enforced here: a request that would wrap the count is never eligible.
    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_elig[i] = i_req[i] && ((i_op[i] == OP_DOWN) ? !w_low : !w_high);
        end
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .i_elig   (w_elig),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign w_ptr_nxt = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_gnt_id  <= '0;
            r_ptr     <= '0;
        end else if (i_load) begin
            r_count   <= i_load_val;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
        end else if (w_any) begin
            r_gnt     <= w_onehot;
            r_gnt_vld <= 1'b1;
            r_gnt_id  <= w_idx;
            r_ptr     <= w_ptr_nxt;
            r_count   <= (i_op[w_idx] == OP_DOWN) ? r_count - 1'b1 : r_count + 1'b1;
        end else begin
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_vld = r_gnt_vld;
    assign o_gnt_id  = r_gnt_id;
    assign o_count   = r_count;
    assign o_high    = w_high;
    assign o_low     = w_low;

endmodule
